// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer turning a load/store into a req/ack
// transaction on a variable-latency data memory.
//   clk, rst          : clock, asynchronous active-high reset
//   mem_read/mem_write: load/store held in EX/MEM
//   size, load_signed : access size (00 byte, 01 half, 1x word), load extension
//   addr, wdata       : byte address, right-aligned store data
//   dmem_*            : registered memory request channel, ack/rdata back
//   stall             : freezes the front of the pipeline while an access runs
//   mem_data          : extended load result towards MEM/WB
//   misalign, bus_err : one-cycle misaligned-access and timeout flags
module dmem_access_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  size,
   input  logic        load_signed,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] mem_data,
   output logic        misalign,
   output logic        bus_err
);
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   state_t      state, state_nx;
   logic        access, aligned, is_byte, is_half, issue, ack_v, timeout_hit;
   logic [1:0]  a_q, size_q;
   logic        sgn_q;
   logic [7:0]  cnt;
   logic [3:0]  be_nx;
   logic [31:0] wdata_nx, load_ext;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   assign access = mem_read | mem_write;
   assign ack_v  = dmem_req & dmem_ack;
   always_comb begin
      is_byte  = size == 2'b00;
      is_half  = size == 2'b01;
      aligned  = is_byte | (is_half & ~addr[0]) | (~is_byte & ~is_half & (addr[1:0] == 2'b00));
      be_nx    = is_byte ? 4'b0001 << addr[1:0] : is_half ? 4'b0011 << addr[1:0] : 4'b1111;
      wdata_nx = is_byte ? {4{wdata[7:0]}} : is_half ? {2{wdata[15:0]}} : wdata;
   end
   always_comb begin
      byte_v   = 8'(dmem_rdata >> {a_q, 3'b000});
      half_v   = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      load_ext = size_q == 2'b00 ? {{24{sgn_q & byte_v[7]}}, byte_v} :
                 size_q == 2'b01 ? {{16{sgn_q & half_v[15]}}, half_v} : dmem_rdata;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;
   // stall is gated by rst so an abandoned transaction releases the pipeline at once
   always_comb begin
      state_nx    = state;
      stall       = 1'b0;
      misalign    = 1'b0;
      issue       = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            issue    = access & aligned & ~rst;
            misalign = access & ~aligned & ~rst;
            stall    = issue;
            state_nx = issue ? BUSY : IDLE;
         end
         BUSY: begin
            stall       = ~rst;
            timeout_hit = ~ack_v & (cnt == CNT_LAST);
            state_nx    = (ack_v | timeout_hit) ? DONE : BUSY;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_be    <= '0;
         mem_data   <= '0;
         bus_err    <= 1'b0;
         cnt        <= '0;
         a_q        <= '0;
         size_q     <= '0;
         sgn_q      <= 1'b0;
      end else begin
         bus_err <= timeout_hit;
         if (issue) begin
            a_q        <= addr[1:0];
            size_q     <= size;
            sgn_q      <= load_signed;
            dmem_addr  <= {addr[31:2], 2'b00};
            dmem_wdata <= wdata_nx;
            dmem_be    <= be_nx;
            dmem_we    <= mem_write;
            dmem_req   <= 1'b1;
            cnt        <= '0;
         end else if (state == BUSY) begin
            if (ack_v) begin
               mem_data <= dmem_we ? 32'd0 : load_ext;
               dmem_req <= 1'b0;
            end else if (timeout_hit) begin
               mem_data <= '0;
               dmem_req <= 1'b0;
            end else begin
               cnt <= cnt + 8'd1;
            end
         end
      end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed scoreboard bench for dmem_access_ctrl with TIMEOUT = 4.
module tb_dmem_access_ctrl;
   logic        clk = 1'b0, rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0, load_signed = 1'b0;
   logic [1:0]  size = 2'b10;
   logic [31:0] addr = '0, wdata = '0;
   logic        dmem_req, dmem_we, dmem_ack = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, mem_data;
   logic [3:0]  dmem_be;
   logic        stall, misalign, bus_err;
   int          checks = 0, errors = 0;
   typedef struct {
      logic [31:0] data;
      logic        err;
      int          stalls;
   } exp_t;
   exp_t sb[$];

   dmem_access_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .size(size),
      .load_signed(load_signed), .addr(addr), .wdata(wdata), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall), .mem_data(mem_data),
      .misalign(misalign), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // delay = number of BUSY cycles without ack before the ack cycle; negative = never ack
   task automatic run(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd, input int delay,
                      input logic [31:0] rdat, input logic [31:0] exp_be, input logic [31:0] exp_wd,
                      input logic [31:0] exp_data, input logic exp_err, input int exp_stalls);
      int   stalls, reqs, n;
      exp_t e;
      sb.push_back('{exp_data, exp_err, exp_stalls});
      @(negedge clk);
      mem_read = rd; mem_write = wr; size = sz; load_signed = sg; addr = ad; wdata = wd;
      dmem_ack = 1'b0;
      #1;
      chk("issue_stall", 32'(stall), 32'd1);
      chk("issue_req_low", 32'(dmem_req), 32'd0);
      stalls = 1; reqs = 0; n = 0;
      do begin
         @(negedge clk);
         dmem_ack   = (n == delay);
         dmem_rdata = (n == delay) ? rdat : 32'h5A5A_5A5A;
         #1;
         if (stall) begin
            stalls++;
            if (dmem_req) reqs++;
         end
         n++;
      end while (stall && n < 300);
      // DONE cycle: access is still presented, yet stall must be low
      dmem_ack = 1'b0;
      chk("done_reached", 32'(stall), 32'd0);
      e = sb.pop_front();
      chk("mem_data", mem_data, e.data);
      chk("bus_err", 32'(bus_err), 32'(e.err));
      chk("stall_cycles", 32'(stalls), 32'(e.stalls));
      chk("req_cycles", 32'(reqs), 32'(e.stalls - 1));
      chk("done_req_low", 32'(dmem_req), 32'd0);
      chk("dmem_addr", dmem_addr, {ad[31:2], 2'b00});
      chk("dmem_be", 32'(dmem_be), exp_be);
      chk("dmem_we", 32'(dmem_we), 32'(wr));
      if (wr) chk("dmem_wdata", dmem_wdata, exp_wd);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   initial begin
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_be", 32'(dmem_be), 32'd0);
      chk("rst_mem_data", mem_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      // aligned word load, ack in first BUSY cycle
      run(1, 0, 2'b10, 0, 32'h0000_1004, 0, 0, 32'hDEAD_BEEF, 32'hF, 0, 32'hDEAD_BEEF, 0, 2);
      // signed byte load, lane 3, ack after 3 idle BUSY cycles
      run(1, 0, 2'b00, 1, 32'h0000_2003, 0, 3, 32'h80FF_1234, 32'h8, 0, 32'hFFFF_FF80, 0, 5);
      // half store at offset 2, back to back with the previous access
      run(0, 1, 2'b01, 0, 32'h0000_3002, 32'h0000_ABCD, 1, 32'h1111_2222, 32'hC, 32'hABCD_ABCD, 0, 0, 3);
      // unsigned upper half load and signed lower half load
      run(1, 0, 2'b01, 0, 32'h0000_4002, 0, 0, 32'h8765_4321, 32'hC, 0, 32'h0000_8765, 0, 2);
      run(1, 0, 2'b01, 1, 32'h0000_4000, 0, 2, 32'h1234_F00D, 32'h3, 0, 32'hFFFF_F00D, 0, 4);
      // byte store at offset 1, size 11 word load
      run(0, 1, 2'b00, 0, 32'h0000_5001, 32'h0000_0077, 0, 0, 32'h2, 32'h7777_7777, 0, 0, 2);
      run(1, 0, 2'b11, 1, 32'h0000_6008, 0, 1, 32'h8000_0001, 32'hF, 0, 32'h8000_0001, 0, 3);
      // misaligned word load: flag only, no request
      @(negedge clk);
      mem_read = 1'b1; size = 2'b10; addr = 32'h0000_7001;
      #1;
      chk("misalign_flag", 32'(misalign), 32'd1);
      chk("misalign_stall", 32'(stall), 32'd0);
      @(negedge clk);
      mem_read = 1'b0;
      #1;
      chk("misalign_req", 32'(dmem_req), 32'd0);
      chk("misalign_clear", 32'(misalign), 32'd0);
      chk("misalign_hold", mem_data, 32'h8000_0001);
      // ack with no request outstanding is ignored
      @(negedge clk);
      dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dmem_ack = 1'b0;
      #1;
      chk("stray_ack_stall", 32'(stall), 32'd0);
      chk("stray_ack_data", mem_data, 32'h8000_0001);
      // timeout: 4 BUSY cycles then DONE with bus_err
      run(1, 0, 2'b10, 0, 32'h0000_8000, 0, -1, 0, 32'hF, 0, 32'd0, 1, 5);
      @(negedge clk);
      #1;
      chk("bus_err_one_cycle", 32'(bus_err), 32'd0);
      chk("post_timeout_stall", 32'(stall), 32'd0);
      // reset in the second BUSY cycle abandons the transaction
      @(negedge clk);
      mem_read = 1'b1; size = 2'b10; addr = 32'h0000_9004;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("busy2_req", 32'(dmem_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(dmem_req), 32'd0);
      chk("arst_stall", 32'(stall), 32'd0);
      chk("arst_addr", dmem_addr, 32'd0);
      chk("arst_be", 32'(dmem_be), 32'd0);
      chk("arst_mem_data", mem_data, 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_read = 1'b0;
      run(1, 0, 2'b00, 0, 32'h0000_A002, 0, 0, 32'h00C3_0000, 32'h4, 0, 32'h0000_00C3, 0, 2);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
